mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester and the load/store requester of the scalar pipeline.
- Allows one outstanding transaction at a time, using a req/gnt/rvalid handshake on both sides.
- Data accesses have priority by default. A discarded-fetch path supports branch/jump redirects.
- Sits between program_counter/fetch and the data-memory stage on one side and a unified memory backend on the other.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request; held high until if_gnt_o
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_flush_i  in  1  discard any accepted fetch not yet returned
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch data valid (1-cycle pulse)
- if_rdata_o  out  DATA_WIDTH  fetch data
- dm_req_i  in  1  data request; held high until dm_gnt_o
- dm_we_i  in  1  1 = store
- dm_size_i  in  2  00 byte, 01 half, 10 word
- dm_addr_i  in  ADDR_WIDTH  data address
- dm_wdata_i  in  DATA_WIDTH  store data
- dm_gnt_o  out  1  data request accepted
- dm_rvalid_o  out  1  load data or store acknowledge
- dm_rdata_o  out  DATA_WIDTH  load data
- mem_req_o  out  1  backend request
- mem_we_o  out  1  backend write enable
- mem_size_o  out  2  backend access size
- mem_addr_o  out  ADDR_WIDTH  backend address
- mem_wdata_o  out  DATA_WIDTH  backend write data
- mem_gnt_i  in  1  backend accepted request
- mem_rvalid_i  in  1  backend response valid; for stores this is the acknowledge
- mem_rdata_i  in  DATA_WIDTH  backend read data
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, owner=NONE, flushed=0, starvation counter=0.
  - All outputs 0, including registered mem_* fields.
  - An in-flight backend response is lost; the backend shares rst_n.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If dm_req_i or if_req_i is high, pick an owner: data wins unless the starvation override applies.
  - Latch the owner's addr/we/size/wdata into mem_* registers. Fetch latches we=0, size=10.
  - Next state REQ.
  - No request: stay in IDLE.
- REQ:
  - mem_req_o=1 and all mem_* fields stay stable until mem_gnt_i.
  - When mem_gnt_i=1, the owner's gnt_o equals 1 in that cycle (combinational from mem_gnt_i). mem_req_o drops next cycle. Next state WAIT.
- WAIT:
  - mem_rvalid_i=1 is routed combinationally to the owner's rvalid_o, and mem_rdata_i to its rdata_o. Next state IDLE.
  - The non-owner's rvalid_o is always 0.
- mem_rvalid_i in IDLE or REQ is ignored. The backend must return rvalid at least 1 cycle after gnt.
- Minimum latency: request seen in cycle N, mem_req_o in N+1, gnt in N+1, rvalid in N+2. One idle cycle follows before the next mem_req_o.
- Flush:
  - if_flush_i is sampled in REQ or WAIT while owner=FETCH, and sets flushed.
  - The transaction still completes on the backend, but if_rvalid_o is suppressed.
  - flushed clears on return to IDLE.
  - if_flush_i has no effect when the owner is data.
  - Flush in the same cycle as mem_rvalid_i also suppresses if_rvalid_o.
- Simultaneous requests in IDLE: exactly one is granted; the loser keeps its req high and is served at the next IDLE decision.
- rdata outputs are 0 whenever the matching rvalid is 0.

Optional Feature:
- MEM_ARB_STARVE_GUARD_EN defined:
  - A counter increments on each data grant issued while if_req_i is high, and clears on any fetch grant.
  - When the counter equals STARVE_LIMIT, the next IDLE decision selects fetch even if dm_req_i is high.
- Undefined: strict data priority and no counter; fetch may starve.

Decomposition:
- mem_arb_pkg holds:
  - state_e {IDLE, REQ, WAIT}
  - owner_e {NONE, FETCH, DATA}
  - mem_size_t (2-bit) with constants SIZE_BYTE, SIZE_HALF, SIZE_WORD
- Single module. The starvation counter is inline; no sub-module is warranted.

Test Plan:
- Fetch only: if_req_i=1, addr 0x100, backend gnt at first mem_req_o, rvalid next cycle with 0x00500093 -> mem_addr_o=0x100, mem_we_o=0, one if_gnt_o pulse, if_rvalid_o with rdata 0x00500093, dm_* outputs 0.
- Contention: if_req_i (0x200) and dm load (0x1000) in the same cycle -> mem_addr_o sequence 0x1000 then 0x200; dm_rvalid_o precedes if_rvalid_o.
- Store: dm_we_i=1, size=10, addr 0x40, wdata 0xDEADBEEF -> mem_we_o=1, mem_wdata_o=0xDEADBEEF; dm_rvalid_o on ack; if_rvalid_o stays 0.
- Backpressure: mem_gnt_i held 0 for 5 cycles -> mem_req_o=1 with stable fields; no gnt pulses; grant on cycle 6.
- Flush and reset:
  - if_flush_i pulsed in WAIT -> if_rvalid_o stays 0; busy_o drops after mem_rvalid_i.
  - rst_n asserted mid-WAIT -> all outputs 0 immediately; state IDLE.
- Starvation: dm_req_i and if_req_i both held high, STARVE_LIMIT=4.
  - With MEM_ARB_STARVE_GUARD_EN: the 5th grant goes to fetch.
  - Without it: no if_gnt_o in 20 transactions.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/load-store memory arbiter: FSM states, port owner
// and the encoding of the backend access size.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_e;

  typedef logic [1:0] mem_size_t;

  localparam mem_size_t SIZE_BYTE = 2'b00;
  localparam mem_size_t SIZE_HALF = 2'b01;
  localparam mem_size_t SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one backend memory port between instruction fetch and load/store,
// one transaction in flight. Optional fetch anti-starvation: MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_flush_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [1:0]            dm_size_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [1:0]            mem_size_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  state_e                state_reg, state_next;
  owner_e                owner_reg, owner_next;
  logic                  flushed_reg, flushed_next;
  logic                  mem_we_reg, mem_we_next;
  mem_size_t             mem_size_reg, mem_size_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
  logic                  starve_hit;
  logic                  pick_fetch;
  logic                  flush_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      owner_reg     <= NONE;
      flushed_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_size_reg  <= SIZE_BYTE;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      flushed_reg   <= flushed_next;
      mem_we_reg    <= mem_we_next;
      mem_size_reg  <= mem_size_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    flushed_next   = flushed_reg;
    mem_we_next    = mem_we_reg;
    mem_size_next  = mem_size_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    pick_fetch     = if_req_i && (!dm_req_i || starve_hit);
    flush_now      = if_flush_i && (owner_reg == FETCH);

    case (state_reg)
      IDLE: begin
        flushed_next = 1'b0;
        if (pick_fetch) begin
          state_next     = REQ;
          owner_next     = FETCH;
          mem_we_next    = 1'b0;
          mem_size_next  = SIZE_WORD;
          mem_addr_next  = if_addr_i;
          mem_wdata_next = '0;
        end else if (dm_req_i) begin
          state_next     = REQ;
          owner_next     = DATA;
          mem_we_next    = dm_we_i;
          mem_size_next  = dm_size_i;
          mem_addr_next  = dm_addr_i;
          mem_wdata_next = dm_wdata_i;
        end
      end
      REQ: begin
        if (flush_now) flushed_next = 1'b1;
        if (mem_gnt_i) state_next = WAIT;
      end
      WAIT: begin
        if (flush_now) flushed_next = 1'b1;
        if (mem_rvalid_i) begin
          state_next   = IDLE;
          owner_next   = NONE;
          flushed_next = 1'b0;
        end
      end
      default: begin
        state_next   = IDLE;
        owner_next   = NONE;
        flushed_next = 1'b0;
      end
    endcase
  end

  // A flush arriving in the same cycle as the response must also hide it.
  assign mem_req_o   = (state_reg == REQ);
  assign if_gnt_o    = mem_req_o && (owner_reg == FETCH) && mem_gnt_i;
  assign dm_gnt_o    = mem_req_o && (owner_reg == DATA) && mem_gnt_i;
  assign if_rvalid_o = (state_reg == WAIT) && (owner_reg == FETCH) && mem_rvalid_i
                       && !flushed_reg && !if_flush_i;
  assign dm_rvalid_o = (state_reg == WAIT) && (owner_reg == DATA) && mem_rvalid_i;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
  assign mem_we_o    = mem_we_reg;
  assign mem_size_o  = mem_size_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign busy_o      = (state_reg != IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_reg;

  // Saturates at the limit so the override stays armed until fetch is served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else if (if_gnt_o) begin
      starve_cnt_reg <= '0;
    end else if (dm_gnt_o && if_req_i && (starve_cnt_reg != LIMIT)) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

  assign starve_hit = (starve_cnt_reg == LIMIT);
`else
  logic starve_limit_unused;

  assign starve_limit_unused = (STARVE_LIMIT > 0);
  assign starve_hit          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small backend model (programmable grant
// stall and response delay); expectations follow the build's starvation option.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LIM = 4;

  logic          clk;
  logic          rst_n;
  logic          if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
  logic [1:0]    dm_size_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i, dm_rdata_o;
  logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [1:0]    mem_size_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic          busy_o;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_size_i(dm_size_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [31:0] resp_of(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return a ^ 32'hC0DE_0000;
  endfunction

  // Backend: grants after gnt_delay stalled cycles, responds resp_delay cycles later.
  int          gnt_delay = 0;
  int          resp_delay = 1;
  int          wait_cnt;
  int          rv_cnt;
  logic        pend;
  logic [31:0] pend_addr;

  assign mem_gnt_i    = mem_req_o && (wait_cnt >= gnt_delay);
  assign mem_rvalid_i = pend && (rv_cnt == 1);
  assign mem_rdata_i  = mem_rvalid_i ? resp_of(pend_addr) : 32'hBAD0_BAD0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= 0;
      rv_cnt    <= 0;
      pend      <= 1'b0;
      pend_addr <= '0;
    end else begin
      if (mem_req_o && !mem_gnt_i) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
      if (mem_req_o && mem_gnt_i) begin
        pend      <= 1'b1;
        rv_cnt    <= resp_delay;
        pend_addr <= mem_addr_o;
      end else if (pend) begin
        if (rv_cnt == 1) pend <= 1'b0;
        else rv_cnt <= rv_cnt - 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event log, written only by sample().
  logic [31:0] g_addr[$];
  logic [31:0] g_wdata[$];
  logic [2:0]  g_wesz[$];
  int          g_own[$];
  int          g_cyc[$];
  int          rv_order[$];
  int          r_cyc[$];
  int          if_gnt_n = 0, dm_gnt_n = 0, if_rv_n = 0, dm_rv_n = 0;
  int          mem_rv_n = 0, stall_n = 0;
  logic        if_gnt_now = 1'b0, dm_gnt_now = 1'b0;
  logic [31:0] if_rdata_last = '0, dm_rdata_last = '0;
  logic        bp_on = 1'b0;
  int          flush_mode = 0;
  logic        flush_done = 1'b0;
  int          drive_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #1;
    if_gnt_now = if_gnt_o;
    dm_gnt_now = dm_gnt_o;
    if (if_gnt_o) if_gnt_n++;
    if (dm_gnt_o) dm_gnt_n++;
    if (mem_req_o && mem_gnt_i) begin
      g_addr.push_back(mem_addr_o);
      g_wdata.push_back(mem_wdata_o);
      g_wesz.push_back({mem_we_o, mem_size_o});
      g_own.push_back(if_gnt_o ? 1 : (dm_gnt_o ? 2 : 0));
      g_cyc.push_back(cyc_n);
    end
    if (mem_req_o && !mem_gnt_i) stall_n++;
    if (mem_rvalid_i) begin
      mem_rv_n++;
      $display("txn %s addr=0x%08h rdata=0x%08h cycle=%0d",
               if_rvalid_o ? "fetch" : (dm_rvalid_o ? "data" : "discarded"),
               pend_addr, mem_rdata_i, cyc_n);
    end
    if (if_rvalid_o) begin
      if_rv_n++;
      if_rdata_last = if_rdata_o;
      rv_order.push_back(1);
      r_cyc.push_back(cyc_n);
      check_eq("rvalid_exclusive", {63'd0, dm_rvalid_o}, 64'd0);
    end else begin
      check_eq("if_rdata_gated", {32'd0, if_rdata_o}, 64'd0);
    end
    if (dm_rvalid_o) begin
      dm_rv_n++;
      dm_rdata_last = dm_rdata_o;
      rv_order.push_back(2);
      r_cyc.push_back(cyc_n);
    end else begin
      check_eq("dm_rdata_gated", {32'd0, dm_rdata_o}, 64'd0);
    end
    if (bp_on && mem_req_o) begin
      check_eq("bp_addr", {32'd0, mem_addr_o}, 64'h80);
      check_eq("bp_wdata", {32'd0, mem_wdata_o}, 64'h1234_5678);
      check_eq("bp_we_size", {61'd0, mem_we_o, mem_size_o}, 64'b101);
    end
  endtask

  task automatic serve(input int max_cyc);
    logic done;
    logic busy_chk;
    done = 1'b0;
    busy_chk = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      tick();
      if (busy_chk) check_eq("flush_busy_drop", {63'd0, busy_o}, 64'd0);
      busy_chk = 1'b0;
      if (if_gnt_now) if_req_i = 1'b0;
      if (dm_gnt_now) dm_req_i = 1'b0;
      if_flush_i = 1'b0;
      if (flush_mode == 1 && mem_req_o && !flush_done) begin
        if_flush_i = 1'b1;
        flush_done = 1'b1;
      end
      if (flush_mode == 2 && if_gnt_now) begin
        if_flush_i = 1'b1;
        busy_chk = 1'b1;
      end
      sample();
      done = !if_req_i && !dm_req_i && !busy_o && !busy_chk;
    end
    check_eq("serve_done", {63'd0, done}, 64'd1);
  endtask

  task automatic run_txn(input logic f, input logic [31:0] fa, input logic d, input logic we,
                         input logic [1:0] sz, input logic [31:0] da, input logic [31:0] wd);
    tick();
    if_req_i   = f;
    if_addr_i  = fa;
    dm_req_i   = d;
    dm_we_i    = we;
    dm_size_i  = sz;
    dm_addr_i  = da;
    dm_wdata_i = wd;
    flush_done = 1'b0;
    sample();
    drive_cyc = cyc_n;
    serve(60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gb, rb, b_ifg, b_dmg, b_ifr, b_dmr, b_mrv, b_st;
    rst_n = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_size_i = SIZE_BYTE; dm_addr_i = '0; dm_wdata_i = '0;

    // Reset holds everything at zero even with a request pending.
    tick();
    dm_req_i = 1'b1; dm_addr_i = 32'h44; dm_we_i = 1'b1;
    tick();
    tick();
    check_eq("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
    check_eq("rst_busy", {63'd0, busy_o}, 64'd0);
    check_eq("rst_mem_addr", {32'd0, mem_addr_o}, 64'd0);
    check_eq("rst_mem_we", {63'd0, mem_we_o}, 64'd0);
    check_eq("rst_mem_size", {62'd0, mem_size_o}, 64'd0);
    check_eq("rst_gnts", {62'd0, if_gnt_o, dm_gnt_o}, 64'd0);
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0;
    tick();
    rst_n = 1'b1;
    sample();

    // Fetch only, minimum latency.
    gb = g_addr.size(); rb = r_cyc.size();
    b_ifg = if_gnt_n; b_dmg = dm_gnt_n; b_ifr = if_rv_n; b_dmr = dm_rv_n;
    run_txn(1'b1, 32'h100, 1'b0, 1'b0, SIZE_BYTE, '0, '0);
    check_eq("fetch_addr", {32'd0, g_addr[gb]}, 64'h100);
    check_eq("fetch_we_size", {61'd0, g_wesz[gb]}, 64'b010);
    check_eq("fetch_gnt_pulses", if_gnt_n - b_ifg, 1);
    check_eq("fetch_rvalid", if_rv_n - b_ifr, 1);
    check_eq("fetch_rdata", {32'd0, if_rdata_last}, 64'h0050_0093);
    check_eq("fetch_dm_quiet", (dm_gnt_n - b_dmg) + (dm_rv_n - b_dmr), 0);
    check_eq("fetch_req_latency", g_cyc[gb] - drive_cyc, 1);
    check_eq("fetch_rvalid_latency", r_cyc[rb] - drive_cyc, 2);

    // Contention: data wins the first decision, fetch follows.
    gb = g_addr.size(); rb = rv_order.size();
    run_txn(1'b1, 32'h200, 1'b1, 1'b0, SIZE_WORD, 32'h1000, '0);
    check_eq("cont_first_addr", {32'd0, g_addr[gb]}, 64'h1000);
    check_eq("cont_second_addr", {32'd0, g_addr[gb+1]}, 64'h200);
    check_eq("cont_first_rvalid", rv_order[rb], 2);
    check_eq("cont_second_rvalid", rv_order[rb+1], 1);
    check_eq("cont_dm_rdata", {32'd0, dm_rdata_last}, 64'hC0DE_1000);
    check_eq("cont_if_rdata", {32'd0, if_rdata_last}, 64'hC0DE_0200);

    // Store word.
    gb = g_addr.size(); b_dmr = dm_rv_n; b_ifr = if_rv_n;
    run_txn(1'b0, '0, 1'b1, 1'b1, SIZE_WORD, 32'h40, 32'hDEAD_BEEF);
    check_eq("store_addr", {32'd0, g_addr[gb]}, 64'h40);
    check_eq("store_we_size", {61'd0, g_wesz[gb]}, 64'b110);
    check_eq("store_wdata", {32'd0, g_wdata[gb]}, 64'hDEAD_BEEF);
    check_eq("store_ack", dm_rv_n - b_dmr, 1);
    check_eq("store_if_quiet", if_rv_n - b_ifr, 0);

    // Byte load.
    gb = g_addr.size();
    run_txn(1'b0, '0, 1'b1, 1'b0, SIZE_BYTE, 32'h41, '0);
    check_eq("byte_we_size", {61'd0, g_wesz[gb]}, 64'b000);
    check_eq("byte_rdata", {32'd0, dm_rdata_last}, 64'hC0DE_0041);

    // Backpressure: five stalled REQ cycles, grant in the sixth.
    gb = g_addr.size(); b_st = stall_n; b_dmg = dm_gnt_n;
    gnt_delay = 5; bp_on = 1'b1;
    run_txn(1'b0, '0, 1'b1, 1'b1, SIZE_HALF, 32'h80, 32'h1234_5678);
    bp_on = 1'b0; gnt_delay = 0;
    check_eq("bp_stall_cycles", stall_n - b_st, 5);
    check_eq("bp_gnt_pulses", dm_gnt_n - b_dmg, 1);
    check_eq("bp_gnt_cycle", g_cyc[gb] - drive_cyc, 6);

    // Flush while in REQ: backend completes, fetch response hidden.
    b_ifg = if_gnt_n; b_ifr = if_rv_n; b_mrv = mem_rv_n;
    gnt_delay = 2; flush_mode = 1;
    run_txn(1'b1, 32'h600, 1'b0, 1'b0, SIZE_BYTE, '0, '0);
    gnt_delay = 0;
    check_eq("flush_req_gnt", if_gnt_n - b_ifg, 1);
    check_eq("flush_req_rvalid", if_rv_n - b_ifr, 0);
    check_eq("flush_req_backend", mem_rv_n - b_mrv, 1);

    // Flush in the same cycle as the response.
    b_ifr = if_rv_n; b_mrv = mem_rv_n;
    flush_mode = 2;
    run_txn(1'b1, 32'h700, 1'b0, 1'b0, SIZE_BYTE, '0, '0);
    check_eq("flush_wait_rvalid", if_rv_n - b_ifr, 0);
    check_eq("flush_wait_backend", mem_rv_n - b_mrv, 1);

    // Flush is ignored while data owns the port.
    b_dmr = dm_rv_n;
    flush_mode = 1;
    run_txn(1'b0, '0, 1'b1, 1'b0, SIZE_WORD, 32'h800, '0);
    flush_mode = 0;
    check_eq("flush_data_rvalid", dm_rv_n - b_dmr, 1);

    // Flushed state does not leak into the next fetch.
    b_ifr = if_rv_n;
    run_txn(1'b1, 32'h100, 1'b0, 1'b0, SIZE_BYTE, '0, '0);
    check_eq("post_flush_rvalid", if_rv_n - b_ifr, 1);

    // Reset in the middle of WAIT.
    resp_delay = 3;
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h500;
    sample();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (if_gnt_now) break;
      sample();
    end
    if_req_i = 1'b0;
    check_eq("midwait_busy", {63'd0, busy_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midwait_rst_req_busy", {62'd0, mem_req_o, busy_o}, 64'd0);
    check_eq("midwait_rst_addr", {32'd0, mem_addr_o}, 64'd0);
    check_eq("midwait_rst_fields", {61'd0, mem_we_o, mem_size_o}, 64'd0);
    check_eq("midwait_rst_wdata", {32'd0, mem_wdata_o}, 64'd0);
    check_eq("midwait_rst_hs", {60'd0, if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o}, 64'd0);
    check_eq("midwait_rst_rdata", {if_rdata_o, dm_rdata_o}, 64'd0);
    sample();
    tick();
    rst_n = 1'b1;
    resp_delay = 1;
    sample();
    b_ifr = if_rv_n;
    run_txn(1'b1, 32'h100, 1'b0, 1'b0, SIZE_BYTE, '0, '0);
    check_eq("after_rst_rvalid", if_rv_n - b_ifr, 1);
    check_eq("after_rst_rdata", {32'd0, if_rdata_last}, 64'h0050_0093);

    // Starvation: both requesters held high for 20 backend grants.
    gb = g_addr.size(); b_ifg = if_gnt_n;
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h3000;
    dm_req_i = 1'b1; dm_addr_i = 32'h2000; dm_we_i = 1'b0; dm_size_i = SIZE_WORD;
    sample();
    for (int c = 0; c < 150; c++) begin
      tick();
      sample();
      if (g_addr.size() - gb >= 20) break;
    end
    check_eq("starve_grants", g_addr.size() - gb >= 20, 1);
    tick();
    if_req_i = 1'b0; dm_req_i = 1'b0;
    sample();
    serve(20);
`ifdef MEM_ARB_STARVE_GUARD_EN
    check_eq("starve_first_four_data", (g_own[gb] == 2 && g_own[gb+1] == 2 &&
             g_own[gb+2] == 2 && g_own[gb+3] == 2), 1);
    check_eq("starve_fifth_owner", g_own[gb+4], 1);
    check_eq("starve_fifth_addr", {32'd0, g_addr[gb+4]}, 64'h3000);
    check_eq("starve_tenth_owner", g_own[gb+9], 1);
`else
    check_eq("starve_no_fetch", if_gnt_n - b_ifg, 0);
    check_eq("starve_fifth_owner", g_own[gb+4], 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
